mem_iface: RTL and testbench

//  Data/instruction memory port between the multi-cycle control unit and a

---
 rtl/mem_iface.sv | 96 +++++++++
 tb/tb_mem_iface.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/mem_iface.sv
// mem_iface: multi-cycle control unit to wait-stated word RAM bridge over a req/ack bus.
// Optional ack watchdog when MEM_TIMEOUT_EN is defined (limit TIMEOUT cycles).
// Ports: clk, rst (async, active high); control side ram_re, ram_we, fetch,
// addr, funct3, wdata -> busy, rdata, rdata_valid, fault; bus side mem_req,
// mem_we, mem_addr, mem_wstrb, mem_wdata -> mem_rdata, mem_ack.
module mem_iface #(
  parameter int AW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ram_re,
  input  logic          ram_we,
  input  logic          fetch,
  input  logic [AW-1:0] addr,
  input  logic [2:0]    funct3,
  input  logic [31:0]   wdata,
  output logic          busy,
  output logic [31:0]   rdata,
  output logic          rdata_valid,
  output logic          fault,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-3:0] mem_addr,
  output logic [3:0]    mem_wstrb,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  input  logic          mem_ack
);
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  state_t state, state_n;
  logic [AW-1:0] a_q;
  logic [2:0] f3_q;
  logic we_q, fault_q, strobe, mis, to_hit;
  logic [31:0] wd_q, sh, ld;
  logic [1:0] sz;
  // A simultaneous write wins, so fetch only forces word width on a pure read.
  assign strobe = ram_re | ram_we;
  assign sz = (ram_re & fetch & ~ram_we) ? 2'd2 : funct3[1:0];
  assign mis = (sz == 2'd1 & addr[0]) | (sz[1] & |addr[1:0]);
`ifdef MEM_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= (state == REQ) ? cnt + 1'b1 : '0;
  assign to_hit = (state == REQ) & ~mem_ack & (cnt == CW'(TIMEOUT - 1));
`else
  assign to_hit = 1'b0;
`endif
  always_comb begin
    state_n = state;
    if (state == IDLE) state_n = strobe ? (mis ? DONE : REQ) : IDLE;
    else if (state == REQ) state_n = (mem_ack | to_hit) ? DONE : REQ;
    else state_n = IDLE;
  end
  // Load lane selection; word accesses are aligned so the shift is zero for them.
  assign sh = mem_rdata >> {a_q[1:0], 3'b000};
  assign ld = (f3_q[1:0] == 2'd0) ? {{24{~f3_q[2] & sh[7]}}, sh[7:0]} :
              (f3_q[1:0] == 2'd1) ? {{16{~f3_q[2] & sh[15]}}, sh[15:0]} : sh;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state   <= IDLE;
      a_q     <= '0;
      f3_q    <= '0;
      we_q    <= 1'b0;
      wd_q    <= '0;
      fault_q <= 1'b0;
      rdata   <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && strobe) begin
        a_q     <= addr;
        f3_q    <= (ram_re & fetch & ~ram_we) ? 3'b010 : funct3;
        we_q    <= ram_we;
        wd_q    <= (sz == 2'd0) ? {4{wdata[7:0]}} : (sz == 2'd1) ? {2{wdata[15:0]}} : wdata;
        fault_q <= mis;
        if (mis) rdata <= '0;
      end
      if (state == REQ && mem_ack && !we_q) rdata <= ld;
      if (to_hit) begin
        fault_q <= 1'b1;
        rdata   <= '0;
      end
    end
  assign busy        = (state == REQ) | (state == IDLE & strobe);
  assign mem_req     = state == REQ;
  assign mem_we      = mem_req & we_q;
  assign mem_addr    = a_q[AW-1:2];
  assign mem_wdata   = wd_q;
  assign mem_wstrb   = ~mem_we ? 4'b0000 :
                       (f3_q[1:0] == 2'd0) ? 4'b0001 << a_q[1:0] :
                       (f3_q[1:0] == 2'd1) ? 4'b0011 << a_q[1:0] : 4'b1111;
  assign rdata_valid = state == DONE;
  assign fault       = rdata_valid & fault_q;
endmodule

// File: tb/tb_mem_iface.sv
module tb_mem_iface;
  logic clk = 0, rst = 1;
  logic ram_re = 0, ram_we = 0, fetch = 0, mem_ack = 0;
  logic [31:0] addr = 0, wdata = 0, mem_rdata = 0;
  logic [2:0] funct3 = 0;
  logic busy, rdata_valid, fault, mem_req, mem_we;
  logic [31:0] rdata, mem_wdata;
  logic [29:0] mem_addr;
  logic [3:0] mem_wstrb;
  int checks = 0, failures = 0;
  logic [31:0] exp_rd = 0;
  mem_iface #(.AW(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .ram_re(ram_re), .ram_we(ram_we), .fetch(fetch),
    .addr(addr), .funct3(funct3), .wdata(wdata), .busy(busy), .rdata(rdata),
    .rdata_valid(rdata_valid), .fault(fault), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic do_txn(input bit re, input bit we, input bit fe, input logic [31:0] a,
                        input logic [2:0] f3, input logic [31:0] wd, input logic [31:0] rd,
                        input int dly);
    int nb, busy_n;
    bit mis;
    logic [31:0] v, ewd;
    logic [3:0] es;
    nb = (re && fe && !we) ? 4 : (f3[1:0] == 0) ? 1 : (f3[1:0] == 1) ? 2 : 4;
    mis = (nb == 2 && a % 2 != 0) || (nb == 4 && a % 4 != 0);
    ewd = (nb == 1) ? (wd & 32'hFF) * 32'h01010101 : (nb == 2) ? (wd & 32'hFFFF) * 32'h00010001 : wd;
    es = (nb == 1) ? 4'(1 << (a % 4)) : (nb == 2) ? 4'(3 << (a % 4)) : 4'hF;
    v = rd >> (8 * (a % 4));
    if (nb == 1) v = (v & 32'hFF) + ((!f3[2] && (v & 32'h80) != 0) ? 32'hFFFFFF00 : 0);
    if (nb == 2) v = (v & 32'hFFFF) + ((!f3[2] && (v & 32'h8000) != 0) ? 32'hFFFF0000 : 0);
    @(negedge clk);
    ram_re = re; ram_we = we; fetch = fe; addr = a; funct3 = f3; wdata = wd;
    #1 chk("busy_strobe", busy, 1);
    busy_n = 1;
    @(negedge clk);
    ram_re = 0; ram_we = 0; fetch = 0; addr = $urandom; funct3 = 3'($urandom); wdata = $urandom;
    #1;
    if (mis) begin
      exp_rd = 0;
      chk("mis_fault", fault, 1);
      chk("mis_valid", rdata_valid, 1);
      chk("mis_rdata", rdata, 0);
      chk("mis_req", mem_req, 0);
      chk("mis_busy", busy, 0);
    end else begin
      for (int i = 0; i <= dly; i++) begin
        chk("req", mem_req, 1);
        chk("req_busy", busy, 1);
        chk("req_valid", rdata_valid, 0);
        chk("req_we", mem_we, we);
        chk("req_addr", mem_addr, a >> 2);
        chk("req_wstrb", mem_wstrb, we ? es : 4'h0);
        if (we) chk("req_wdata", mem_wdata, ewd);
        busy_n++;
        mem_rdata = (i == dly) ? rd : $urandom;
        mem_ack = (i == dly);
        @(negedge clk);
        mem_ack = 0;
        #1;
      end
      if (!we) exp_rd = v;
      chk("done_valid", rdata_valid, 1);
      chk("done_fault", fault, 0);
      chk("done_rdata", rdata, exp_rd);
      chk("done_busy", busy, 0);
      chk("done_req", mem_req, 0);
    end
    @(negedge clk);
    #1;
    chk("idle_valid", rdata_valid, 0);
    chk("idle_hold", rdata, exp_rd);
    chk("idle_busy", busy, 0);
    if (!mis && dly == 2) chk("busy_cycles", busy_n, 4);
  endtask
  initial begin
    logic [2:0] f3s [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_valid", rdata_valid, 0);
    chk("rst_fault", fault, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_wstrb", mem_wstrb, 0);
    chk("rst_we", mem_we, 0);
    rst = 0;
    do_txn(1, 0, 1, 32'h100, 3'd0, 0, 32'h00500093, 2);
    do_txn(1, 0, 0, 32'h203, 3'd0, 0, 32'h80FF1234, 0);
    chk("lb", rdata, 32'hFFFFFF80);
    do_txn(1, 0, 0, 32'h203, 3'd4, 0, 32'h80FF1234, 1);
    chk("lbu", rdata, 32'h00000080);
    do_txn(1, 0, 0, 32'h202, 3'd1, 0, 32'h80FF1234, 0);
    chk("lh", rdata, 32'hFFFF80FF);
    do_txn(0, 1, 0, 32'h11, 3'd0, 32'hAB, 0, 0);
    chk("sb_hold", rdata, 32'hFFFF80FF);
    do_txn(1, 0, 0, 32'h6, 3'd2, 0, 0, 0);
    do_txn(1, 1, 0, 32'h40, 3'd2, 32'hDEADBEEF, 32'h12345678, 1);
    // reset in the middle of a request
    @(negedge clk);
    ram_re = 1; addr = 32'h80; funct3 = 3'd2;
    @(negedge clk);
    ram_re = 0;
    #1 chk("r5_req_before", mem_req, 1);
    rst = 1;
    #1;
    chk("r5_req", mem_req, 0);
    chk("r5_busy", busy, 0);
    chk("r5_rdata", rdata, 0);
    exp_rd = 0;
    @(negedge clk);
    rst = 0;
    do_txn(1, 0, 0, 32'h84, 3'd2, 0, 32'hCAFEF00D, 1);
    chk("r5_lw", rdata, 32'hCAFEF00D);
    for (int n = 0; n < 80; n++) begin
      bit re, we;
      re = 1'($urandom); we = 1'($urandom);
      if (!re && !we) re = 1;
      do_txn(re, we, 1'($urandom), $urandom_range(0, 4095), f3s[$urandom_range(0, 4)],
             $urandom, $urandom, $urandom_range(0, 2));
    end
    // unanswered request
    @(negedge clk);
    ram_re = 1; addr = 32'h300; funct3 = 3'd2;
    @(negedge clk);
    ram_re = 0;
    #1;
`ifdef MEM_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      chk("to_req", mem_req, 1);
      @(negedge clk);
      #1;
    end
    chk("to_req_drop", mem_req, 0);
    chk("to_fault", fault, 1);
    chk("to_valid", rdata_valid, 1);
    chk("to_rdata", rdata, 0);
    mem_ack = 1;
    @(negedge clk);
    mem_ack = 0;
    #1;
    chk("to_stray_valid", rdata_valid, 0);
    chk("to_stray_req", mem_req, 0);
`else
    begin
      int drops;
      drops = 0;
      repeat (1000) begin
        if (!mem_req) drops++;
        @(negedge clk);
        #1;
      end
      chk("hang_drops", drops, 0);
      chk("hang_req", mem_req, 1);
      chk("hang_valid", rdata_valid, 0);
    end
    rst = 1;
    #1 chk("hang_rst", mem_req, 0);
    @(negedge clk);
    rst = 0;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
